// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: tag encoding, default widths and the register/RS entry type.
package tomasulo_pkg;

  localparam int unsigned NumRegs = 32;
  localparam int unsigned IdxW    = $clog2(NumRegs);
  localparam int unsigned DataW   = 32;
  localparam int unsigned TagW    = 5;

  // All-ones tag marks a value as ready (no pending producer).
  function automatic int unsigned invalid_tag(input int unsigned tag_w);
    return (32'd1 << tag_w) - 32'd1;
  endfunction

  typedef struct packed {
    logic [DataW-1:0] val;
    logic [TagW-1:0]  tag;
  } entry_t;

endpackage

// File: rtl/reg_status_read_port.sv
// One source-operand port: range check, zero-register force and same-cycle CDB bypass.
module reg_status_read_port
  import tomasulo_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TAG_W    = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic [IDX_W-1:0]  rd_reg_i,
  input  logic [DATA_W-1:0] ent_val_i,
  input  logic [TAG_W-1:0]  ent_tag_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_val_i,
  output logic [DATA_W-1:0] rd_val_o,
  output logic [TAG_W-1:0]  rd_tag_o
);

  localparam logic [TAG_W-1:0] InvTag = TAG_W'(invalid_tag(TAG_W));

  logic in_range, is_zero, bypass;

  always_comb begin
    in_range = 32'(rd_reg_i) < NUM_REGS;
    is_zero  = ZERO_REG && (rd_reg_i == '0);
    bypass   = cdb_valid_i && (cdb_tag_i != InvTag) && (ent_tag_i == cdb_tag_i);
    rd_val_o = ent_val_i;
    rd_tag_o = ent_tag_i;
    if (!in_range || is_zero) begin
      rd_val_o = '0;
      rd_tag_o = InvTag;
    end else if (bypass) begin
      rd_val_o = cdb_val_i;
      rd_tag_o = InvTag;
    end
  end

endmodule

// File: rtl/reg_status_file.sv
// Register status table for issue: per-register value and producer tag, multi-port
// registered reads with CDB bypass, destination rename, CDB snoop and flush.
module reg_status_file
  import tomasulo_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TAG_W    = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS),
  parameter int unsigned CNT_W    = $clog2(NUM_REGS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_rd_valid,
  input  logic [NUM_RD*IDX_W-1:0]  in_rd_reg,
  output logic                     out_rd_valid,
  output logic [NUM_RD*DATA_W-1:0] out_rd_val,
  output logic [NUM_RD*TAG_W-1:0]  out_rd_tag,
  input  logic                     in_rename_valid,
  input  logic [IDX_W-1:0]         in_rename_reg,
  input  logic [TAG_W-1:0]         in_rename_tag,
  input  logic                     in_cdb_valid,
  input  logic [TAG_W-1:0]         in_cdb_tag,
  input  logic [DATA_W-1:0]        in_cdb_val,
  input  logic                     in_flush,
  output logic [CNT_W-1:0]         out_busy_count
);

  localparam logic [TAG_W-1:0] InvTag = TAG_W'(invalid_tag(TAG_W));

  logic [DATA_W-1:0] val_q [NUM_REGS];
  logic [DATA_W-1:0] val_d [NUM_REGS];
  logic [TAG_W-1:0]  tag_q [NUM_REGS];
  logic [TAG_W-1:0]  tag_d [NUM_REGS];

  logic                     rd_valid_q, rd_valid_d;
  logic [NUM_RD*DATA_W-1:0] rd_val_q, rd_val_d;
  logic [NUM_RD*TAG_W-1:0]  rd_tag_q, rd_tag_d;
  logic [CNT_W-1:0]         busy_q, busy_d;

  logic [NUM_RD*DATA_W-1:0] port_val;
  logic [NUM_RD*TAG_W-1:0]  port_tag;
  logic [NUM_RD*DATA_W-1:0] sel_val;
  logic [NUM_RD*TAG_W-1:0]  sel_tag;

  logic cdb_live, rename_ok;

  // Entry selection by compare keeps out-of-range indices from reaching the array.
  always_comb begin
    sel_val = '0;
    sel_tag = {NUM_RD{InvTag}};
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (32'(in_rd_reg[k*IDX_W +: IDX_W]) == r) begin
          sel_val[k*DATA_W +: DATA_W] = val_q[r];
          sel_tag[k*TAG_W +: TAG_W]   = tag_q[r];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    reg_status_read_port #(
      .NUM_REGS (NUM_REGS),
      .DATA_W   (DATA_W),
      .TAG_W    (TAG_W),
      .ZERO_REG (ZERO_REG),
      .IDX_W    (IDX_W)
    ) u_port (
      .rd_reg_i    (in_rd_reg[k*IDX_W +: IDX_W]),
      .ent_val_i   (sel_val[k*DATA_W +: DATA_W]),
      .ent_tag_i   (sel_tag[k*TAG_W +: TAG_W]),
      .cdb_valid_i (in_cdb_valid),
      .cdb_tag_i   (in_cdb_tag),
      .cdb_val_i   (in_cdb_val),
      .rd_val_o    (port_val[k*DATA_W +: DATA_W]),
      .rd_tag_o    (port_tag[k*TAG_W +: TAG_W])
    );
  end

  // Tag priority: flush > rename > CDB; CDB value writes land regardless.
  always_comb begin
    cdb_live  = in_cdb_valid && (in_cdb_tag != InvTag);
    rename_ok = in_rename_valid && !in_flush && (in_rename_tag != InvTag) &&
                (32'(in_rename_reg) < NUM_REGS) && !(ZERO_REG && (in_rename_reg == '0));
    busy_d    = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      val_d[r] = val_q[r];
      tag_d[r] = tag_q[r];
      if (cdb_live && (tag_q[r] == in_cdb_tag)) begin
        val_d[r] = in_cdb_val;
        tag_d[r] = InvTag;
      end
      if (rename_ok && (32'(in_rename_reg) == r)) tag_d[r] = in_rename_tag;
      if (in_flush) tag_d[r] = InvTag;
      if (tag_d[r] != InvTag) busy_d = busy_d + CNT_W'(1);
    end
  end

  always_comb begin
    rd_valid_d = in_rd_valid;
    rd_val_d   = rd_val_q;
    rd_tag_d   = rd_tag_q;
    if (in_rd_valid) begin
      rd_val_d = port_val;
      rd_tag_d = port_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        val_q[r] <= '0;
        tag_q[r] <= InvTag;
      end
      rd_valid_q <= 1'b0;
      rd_val_q   <= '0;
      rd_tag_q   <= {NUM_RD{InvTag}};
      busy_q     <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        val_q[r] <= val_d[r];
        tag_q[r] <= tag_d[r];
      end
      rd_valid_q <= rd_valid_d;
      rd_val_q   <= rd_val_d;
      rd_tag_q   <= rd_tag_d;
      busy_q     <= busy_d;
    end
  end

  assign out_rd_valid   = rd_valid_q;
  assign out_rd_val     = rd_val_q;
  assign out_rd_tag     = rd_tag_q;
  assign out_busy_count = busy_q;

endmodule

// File: tb/tb_reg_status_file.sv
// Directed bench for reg_status_file with default parameters (32 regs, 2 read ports).
module tb_reg_status_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_rd_valid;
  logic [9:0]  in_rd_reg;
  logic        out_rd_valid;
  logic [63:0] out_rd_val;
  logic [9:0]  out_rd_tag;
  logic        in_rename_valid;
  logic [4:0]  in_rename_reg;
  logic [4:0]  in_rename_tag;
  logic        in_cdb_valid;
  logic [4:0]  in_cdb_tag;
  logic [31:0] in_cdb_val;
  logic        in_flush;
  logic [5:0]  out_busy_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_status_file dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_rd_valid     (in_rd_valid),
    .in_rd_reg       (in_rd_reg),
    .out_rd_valid    (out_rd_valid),
    .out_rd_val      (out_rd_val),
    .out_rd_tag      (out_rd_tag),
    .in_rename_valid (in_rename_valid),
    .in_rename_reg   (in_rename_reg),
    .in_rename_tag   (in_rename_tag),
    .in_cdb_valid    (in_cdb_valid),
    .in_cdb_tag      (in_cdb_tag),
    .in_cdb_val      (in_cdb_val),
    .in_flush        (in_flush),
    .out_busy_count  (out_busy_count)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_rd_valid     = 1'b0;
    in_rename_valid = 1'b0;
    in_cdb_valid    = 1'b0;
    in_flush        = 1'b0;
  endtask

  task automatic rd(input logic [4:0] r1, input logic [4:0] r0);
    in_rd_valid = 1'b1;
    in_rd_reg   = {r1, r0};
  endtask

  task automatic ren(input logic [4:0] r, input logic [4:0] t);
    in_rename_valid = 1'b1;
    in_rename_reg   = r;
    in_rename_tag   = t;
  endtask

  task automatic cdb(input logic [4:0] t, input logic [31:0] v);
    in_cdb_valid = 1'b1;
    in_cdb_tag   = t;
    in_cdb_val   = v;
  endtask

  initial begin
    idle();
    in_rd_reg = '0; in_rename_reg = '0; in_rename_tag = '0;
    in_cdb_tag = '0; in_cdb_val = '0;
    rst_n = 1'b0;
    #12;
    chk("rst_valid", 64'(out_rd_valid), 64'd0);
    chk("rst_val", out_rd_val, 64'd0);
    chk("rst_tag", 64'(out_rd_tag), 64'h3FF);
    chk("rst_busy", 64'(out_busy_count), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    rd(5'd4, 5'd3); step(); idle();
    chk("r3r4_valid", 64'(out_rd_valid), 64'd1);
    chk("r3r4_val", out_rd_val, 64'd0);
    chk("r3r4_tag", 64'(out_rd_tag), 64'h3FF);
    chk("r3r4_busy", 64'(out_busy_count), 64'd0);
    step();
    chk("valid_pulse", 64'(out_rd_valid), 64'd0);
    chk("tag_hold", 64'(out_rd_tag), 64'h3FF);

    ren(5'd5, 5'd7); step(); idle();
    chk("ren5_busy", 64'(out_busy_count), 64'd1);
    rd(5'd5, 5'd5); step(); idle();
    chk("r5_tag", 64'(out_rd_tag), {54'd0, 5'd7, 5'd7});

    rd(5'd5, 5'd5); cdb(5'd7, 32'h1234); step(); idle();
    chk("bypass_val", out_rd_val, {32'h1234, 32'h1234});
    chk("bypass_tag", 64'(out_rd_tag), 64'h3FF);
    chk("bypass_busy", 64'(out_busy_count), 64'd0);
    rd(5'd5, 5'd5); step(); idle();
    chk("r5_after_val", out_rd_val, {32'h1234, 32'h1234});
    chk("r5_after_tag", 64'(out_rd_tag), 64'h3FF);

    ren(5'd2, 5'd4); step();
    ren(5'd9, 5'd4); step(); idle();
    chk("r2r9_busy", 64'(out_busy_count), 64'd2);
    cdb(5'd4, 32'hAA); ren(5'd9, 5'd6); step(); idle();
    chk("cdb_ren_busy", 64'(out_busy_count), 64'd1);
    rd(5'd9, 5'd2); step(); idle();
    chk("r2r9_val", out_rd_val, {32'hAA, 32'hAA});
    chk("r2r9_tag", 64'(out_rd_tag), {54'd0, 5'd6, 5'd31});

    ren(5'd0, 5'd3); step(); idle();
    chk("r0_busy", 64'(out_busy_count), 64'd1);
    rd(5'd0, 5'd0); step(); idle();
    chk("r0_val", out_rd_val, 64'd0);
    chk("r0_tag", 64'(out_rd_tag), 64'h3FF);

    ren(5'd31, 5'd2); step(); idle();
    chk("r31_ren_busy", 64'(out_busy_count), 64'd2);
    cdb(5'd2, 32'd5); step(); idle();
    chk("r31_cdb_busy", 64'(out_busy_count), 64'd1);
    rd(5'd9, 5'd31); step(); idle();
    chk("r31r9_val", out_rd_val, {32'hAA, 32'd5});
    chk("r31r9_tag", 64'(out_rd_tag), {54'd0, 5'd6, 5'd31});

    cdb(5'd31, 32'hDEAD); step(); idle();
    rd(5'd2, 5'd5); step(); idle();
    chk("inv_cdb_val", out_rd_val, {32'hAA, 32'h1234});

    ren(5'd10, 5'd8); step();
    ren(5'd11, 5'd9); step(); idle();
    chk("three_busy", 64'(out_busy_count), 64'd3);
    in_flush = 1'b1; ren(5'd8, 5'd12); cdb(5'd9, 32'h77); step(); idle();
    chk("flush_busy", 64'(out_busy_count), 64'd0);
    rd(5'd11, 5'd8); step(); idle();
    chk("flush_tag", 64'(out_rd_tag), 64'h3FF);
    chk("flush_val", out_rd_val, {32'h77, 32'd0});

    ren(5'd12, 5'd3); step(); idle();
    chk("pre_rst_busy", 64'(out_busy_count), 64'd1);
    rd(5'd12, 5'd12); step();
    chk("pre_rst_valid", 64'(out_rd_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(out_rd_valid), 64'd0);
    chk("async_tag", 64'(out_rd_tag), 64'h3FF);
    chk("async_busy", 64'(out_busy_count), 64'd0);
    step();
    rst_n = 1'b1;
    rd(5'd12, 5'd9); step(); idle();
    chk("post_rst_val", out_rd_val, 64'd0);
    chk("post_rst_tag", 64'(out_rd_tag), 64'h3FF);
    chk("post_rst_valid", 64'(out_rd_valid), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
